fetch_unit: RTL and testbench

- Instruction fetch front-end between the block RAM and the CPU decode stage.
- Generates word addresses, issues BRAM reads, and byte-swaps little-endian words to big-endian ordering.
- Buffers fetched words with their PC in a 2-entry queue.
- Hands instructions to decode over a valid/ready handshake, so the CPU no longer computes the fetch address itself.
- Supports redirect on branch: flushes the queue and discards any read in flight.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/fetch_unit_if.sv | 29 ++
 rtl/fetch_queue.sv | 72 +++++++
 rtl/fetch_unit.sv | 98 +++++++++
 tb/tb_fetch_unit.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the instruction fetch path: FSM encoding, queue entry
// layout and the byte-lane swap applied to BRAM read data.
package cpu_pkg;

  localparam int INST_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [31:0]       pc;
  } fetch_entry_t;

  function automatic logic [INST_W-1:0] BYTE_SWAP(input logic [INST_W-1:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: run/redirect control, BRAM read port and the
// decode-side valid/ready instruction handshake.
interface fetch_unit_if #(
  parameter int ADDR_W = 18
);
  import cpu_pkg::*;

  logic              enable;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              bram_enable;
  logic [ADDR_W-1:0] bram_addr;
  logic [INST_W-1:0] bram_data;
  logic              inst_valid;
  logic [INST_W-1:0] inst;
  logic [31:0]       inst_pc;
  logic              inst_ready;

  modport master (
    input  enable, redirect_valid, redirect_pc, bram_data, inst_ready,
    output bram_enable, bram_addr, inst_valid, inst, inst_pc
  );

  modport slave (
    output enable, redirect_valid, redirect_pc, bram_data, inst_ready,
    input  bram_enable, bram_addr, inst_valid, inst, inst_pc
  );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry shifting FIFO of {inst, pc}; entry 0 is always the head so the
// output is a plain register with no read mux.
module fetch_queue
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         n_reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t e0_q, e0_d, e1_q, e1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_pop;

  assign do_pop = pop && (cnt_q != 2'd0);

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      case ({push, do_pop})
        2'b10: begin
          if (cnt_q == 2'd0) e0_d = push_data;
          else               e1_d = push_data;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          e0_d  = e1_q;
          cnt_d = cnt_q - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new word lands behind whatever remains.
          if (cnt_q == 2'd1) begin
            e0_d = push_data;
          end else begin
            e0_d = e1_q;
            e1_d = push_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign head  = e0_q;

  // The issue rule reserves a slot for every read in flight.
  a_no_overflow: assert property (@(posedge clk) disable iff (!n_reset)
    !(push && cnt_q == 2'd2));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: walks the PC, reads BRAM one word per cycle,
// endian-corrects the data and hands {inst, pc} to decode via a 2-entry queue.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int          ADDR_W        = 18,
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter bit          LITTLE_ENDIAN = 1'b1
)(
  input  logic         clk,
  input  logic         n_reset,
  fetch_unit_if.master bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  inflight_pc_q, inflight_pc_d;
  logic         inflight_q, inflight_d;
  logic         issue, pop, push, inst_valid;
  logic [1:0]   count;
  logic [2:0]   occ;
  fetch_entry_t push_data, head;
  logic         unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

  assign inst_valid = (count != 2'd0);
  assign pop        = inst_valid && bus.inst_ready;
  assign occ        = {1'b0, count} + {2'b00, inflight_q};

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.enable)  state_d = RUN;
      RUN:     if (!bus.enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A slot freed by this cycle's pop may be claimed by this cycle's issue.
  always_comb begin
    issue = 1'b0;
    if (state_q == RUN && !bus.redirect_valid && occ < (3'd2 + {2'b00, pop}))
      issue = 1'b1;
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = issue;
    if (bus.redirect_valid) begin
      fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
    end else if (issue) begin
      fetch_pc_d    = fetch_pc_q + 32'd4;
      inflight_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= 32'h0;
      inflight_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
    end
  end

  // Data returning for a read issued just before a redirect is dropped here.
  assign push           = inflight_q && !bus.redirect_valid;
  assign push_data.inst = LITTLE_ENDIAN ? BYTE_SWAP(bus.bram_data) : bus.bram_data;
  assign push_data.pc   = inflight_pc_q;

  fetch_queue u_queue (
    .clk       (clk),
    .n_reset   (n_reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (bus.redirect_valid),
    .count     (count),
    .head      (head)
  );

  assign bus.bram_enable = issue;
  assign bus.bram_addr   = fetch_pc_q[ADDR_W+1:2];
  assign bus.inst_valid  = inst_valid;
  assign bus.inst        = head.inst;
  assign bus.inst_pc     = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a scoreboard of expected {inst, pc} is filled
// by the stimulus and drained by negedge monitors on accepted instructions.
module tb_fetch_unit;
  import cpu_pkg::*;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(18)) bus  ();
  fetch_unit_if #(.ADDR_W(18)) bus2 ();

  fetch_unit #(.ADDR_W(18), .RESET_PC(32'h0), .LITTLE_ENDIAN(1'b1)) dut (
    .clk(clk), .n_reset(n_reset), .bus(bus.master));

  fetch_unit #(.ADDR_W(18), .RESET_PC(32'h0), .LITTLE_ENDIAN(1'b0)) dut_be (
    .clk(clk), .n_reset(n_reset), .bus(bus2.master));

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t exp2_q[$];

  function automatic logic [31:0] mem_word(input logic [17:0] a);
    if (a == 18'h0) return 32'h0A00A0E3;
    return {a[7:0], 8'h5A, ~a[7:0], 8'h3C};
  endfunction

  // Big-endian view of mem_word, written out lane by lane.
  function automatic logic [31:0] exp_inst(input logic [31:0] pc);
    logic [17:0] a;
    a = pc[19:2];
    if (a == 18'h0) return 32'hE3A0000A;
    return {8'h3C, ~a[7:0], 8'h5A, a[7:0]};
  endfunction

  always_ff @(posedge clk) begin
    if (bus.bram_enable)  bus.bram_data  <= mem_word(bus.bram_addr);
    if (bus2.bram_enable) bus2.bram_data <= 32'h11223344;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.inst = exp_inst(pc);
    e.pc   = pc;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin : mon_le
    exp_t e;
    if (n_reset && bus.inst_valid && bus.inst_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_inst: actual pc=%h required=none", bus.inst_pc);
      end else begin
        e = exp_q.pop_front();
        chk("inst", bus.inst, e.inst);
        chk("inst_pc", bus.inst_pc, e.pc);
      end
    end
  end

  always @(negedge clk) begin : mon_be
    exp_t e;
    if (n_reset && bus2.inst_valid && bus2.inst_ready) begin
      if (exp2_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_inst_be: actual pc=%h required=none", bus2.inst_pc);
      end else begin
        e = exp2_q.pop_front();
        chk("inst_be", bus2.inst, e.inst);
        chk("inst_pc_be", bus2.inst_pc, e.pc);
      end
    end
  end

  task automatic wait_drain(input bit second, input int budget);
    int n = 0;
    while ((second ? exp2_q.size() : exp_q.size()) != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk(second ? "drain_be" : "drain", 32'(second ? exp2_q.size() : exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.enable = 1'b0;  bus.redirect_valid = 1'b0;  bus.redirect_pc = 32'h0;  bus.inst_ready = 1'b0;
    bus2.enable = 1'b0; bus2.redirect_valid = 1'b0; bus2.redirect_pc = 32'h0; bus2.inst_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_bram_enable", 32'(bus.bram_enable), 32'd0);
    chk("rst_bram_addr", 32'(bus.bram_addr), 32'd0);
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_inst", bus.inst, 32'h0);
    chk("rst_inst_pc", bus.inst_pc, 32'h0);
    @(posedge clk); #1 n_reset = 1'b1;

    // Streaming with decode always ready
    bus.inst_ready = 1'b1;
    for (int k = 0; k < 5; k++) push_exp(32'(k * 4));
    bus.enable = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stream_bram_enable", 32'(bus.bram_enable), 32'd1);
      chk("stream_bram_addr", 32'(bus.bram_addr), 32'(i));
      chk("stream_inst_valid", 32'(bus.inst_valid), (i >= 2) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1 bus.enable = 1'b0;
    wait_drain(1'b0, 40);
    chk("idle_bram_enable", 32'(bus.bram_enable), 32'd0);

    // Backpressure: two reads outstanding, then stall with a stable head
    bus.inst_ready = 1'b0;
    push_exp(32'h14); push_exp(32'h18); push_exp(32'h1C); push_exp(32'h20); push_exp(32'h24);
    @(posedge clk); #1 bus.enable = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_bram_enable", 32'(bus.bram_enable), (i < 2) ? 32'd1 : 32'd0);
      if (i >= 2) begin
        chk("bp_inst_valid", 32'(bus.inst_valid), 32'd1);
        chk("bp_inst_pc_stable", bus.inst_pc, 32'h14);
        chk("bp_inst_stable", bus.inst, exp_inst(32'h14));
      end
    end
    @(posedge clk); #1 bus.inst_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.enable = 1'b0;
    wait_drain(1'b0, 40);

    // Redirect while the read of 0x28 is in flight
    push_exp(32'h100); push_exp(32'h104);
    @(posedge clk); #1 bus.enable = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0103;
    @(negedge clk);
    chk("redir_no_issue", 32'(bus.bram_enable), 32'd0);
    @(posedge clk); #1 bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir_bram_enable", 32'(bus.bram_enable), 32'd1);
    chk("redir_bram_addr", 32'(bus.bram_addr), 32'h40);
    chk("redir_inst_valid", 32'(bus.inst_valid), 32'd0);
    @(posedge clk); #1 bus.enable = 1'b0;
    wait_drain(1'b0, 40);

    // PC wrap at the top of the address space
    push_exp(32'hFFFF_FFFC); push_exp(32'h0);
    @(posedge clk); #1 bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC; bus.enable = 1'b1;
    @(posedge clk); #1 bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("wrap_bram_addr_top", 32'(bus.bram_addr), 32'h3FFFF);
    chk("wrap_bram_enable", 32'(bus.bram_enable), 32'd1);
    @(posedge clk); #1 bus.enable = 1'b0;
    @(negedge clk);
    chk("wrap_bram_addr_zero", 32'(bus.bram_addr), 32'h0);
    chk("wrap_bram_enable2", 32'(bus.bram_enable), 32'd1);
    wait_drain(1'b0, 40);

    // Asynchronous reset between edges with a full queue
    bus.inst_ready = 1'b0;
    @(posedge clk); #1 bus.enable = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("pre_arst_inst_valid", 32'(bus.inst_valid), 32'd1);
    #2 n_reset = 1'b0;
    #1;
    chk("arst_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("arst_bram_enable", 32'(bus.bram_enable), 32'd0);
    chk("arst_bram_addr", 32'(bus.bram_addr), 32'h0);
    chk("arst_inst_pc", bus.inst_pc, 32'h0);
    chk("arst_inst", bus.inst, 32'h0);
    push_exp(32'h0); push_exp(32'h4);
    bus.inst_ready = 1'b1;
    @(posedge clk); #1 n_reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("restart_bram_enable", 32'(bus.bram_enable), 32'd1);
    chk("restart_bram_addr", 32'(bus.bram_addr), 32'h0);
    @(posedge clk); #1 bus.enable = 1'b0;
    wait_drain(1'b0, 40);

    // Pass-through build: no byte swap
    exp2_q.push_back({32'h11223344, 32'h0});
    bus2.inst_ready = 1'b1;
    @(posedge clk); #1 bus2.enable = 1'b1;
    @(posedge clk); #1 bus2.enable = 1'b0;
    wait_drain(1'b1, 40);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
